sram_mem_controller: RTL and testbench
======================================

Name: sram_mem_controller

Overview:
- Sits in the MEM stage, between the EXE_Stage_Reg outputs (ALU_res as address, val_Rm as store data, mem_read/mem_write) and an external 16-bit asynchronous SRAM.
- Performs each 32-bit word access as two 16-bit SRAM phases with a programmable wait count per phase.
- Drives `ready` low while an access is in flight; top level uses `~ready` as the pipeline-wide freeze.

Parameters:
- WAIT_CYCLES, 3, cycles per 16-bit SRAM phase; legal range 2..15.
- MEM_BASE, 1024, byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM halfword address width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  load request from EXE_Stage_Reg mem_read_out
- wr_en  in  1  store request from EXE_Stage_Reg mem_write_out
- address  in  32  byte address (ALU_res)
- write_data  in  32  store data (val_Rm)
- read_data  out  32  loaded word, held until the next read completes
- ready  out  1  1 = no access pending or access completing this cycle
- sram_addr  out  SRAM_AW  halfword address
- sram_dq_out  out  16  write data to SRAM
- sram_dq_in  in  16  read data from SRAM
- sram_dq_oe  out  1  1 = controller drives the DQ bus
- sram_we_n  out  1  active-low write strobe
- sram_oe_n  out  1  active-low output enable

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high.
  - On rst=1 at a rising edge: state=IDLE, counter=0, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
  - ready=1 while rst is held, because rd_en/wr_en are ignored in reset.
  - Reset mid-access aborts the access. Partial read data is discarded and partial SRAM writes are not rolled back.
- Address mapping: word = (address - MEM_BASE) >> 2, 32-bit arithmetic. sram_addr = {word[SRAM_AW-2:0], half}, with half=0 for the LOW phase and 1 for the HIGH phase. Out-of-range addresses wrap by truncation and raise no error.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if rd_en|wr_en, latch address, write_data and op (wr_en has priority when both are set), then go to LOW. ready=0 in this cycle.
  - LOW: counter runs 0..WAIT_CYCLES-1, then go to HIGH and clear the counter.
  - HIGH: same counting, then go to DONE.
  - DONE: ready=1 for exactly one cycle, then go to IDLE. The pipeline advances on this edge.
- Latency: a request first seen in cycle 0 gets ready=1 in cycle 2*WAIT_CYCLES+1; 8 cycles total at the default. Back-to-back requests pass through IDLE, so every access costs 2*WAIT_CYCLES+2 cycles.
- ready = (state==IDLE & ~(rd_en|wr_en)) | state==DONE. This is combinational from the state and the request inputs.
- Writes:
  - sram_dq_oe=1 throughout LOW and HIGH.
  - sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH.
  - sram_we_n=0 for counter 0..WAIT_CYCLES-2 and 1 on the final cycle of each phase, giving a hold margin.
  - sram_oe_n=1.
- Reads:
  - sram_oe_n=0 and sram_dq_oe=0 during LOW and HIGH; sram_we_n=1.
  - sram_dq_in is sampled on the last cycle of LOW into read_data[15:0] and on the last cycle of HIGH into read_data[31:16].
  - read_data is otherwise unchanged.
- Inputs are latched at IDLE→LOW. Changes or deassertion of rd_en/wr_en/address during LOW, HIGH or DONE have no effect.
- Outside LOW/HIGH: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.

Decomposition:
- Shared package `arm_mem_pkg`:
  - state enum {IDLE, LOW, HIGH, DONE}
  - MEM_BASE
  - SRAM_AW and SRAM_DW=16
  - word-width constant 32
- One natural sub-module: `sram_phase_timer`, the wait counter with `start`, `last` and `count` outputs, reused by both phases.
- A behavioural SRAM model lives only in the testbench.

Test Plan:
- Reset release, no requests: ready=1, sram_we_n=1, sram_oe_n=1, read_data=0.
- Store 0xDEADBEEF to address 1024:
  - sram_addr=0 with dq_out=0xBEEF, then sram_addr=1 with dq_out=0xDEAD.
  - we_n low for 2 cycles per phase.
  - ready returns high in cycle 7.
- Load from address 1024 after the previous store, with the SRAM model: read_data=0xDEADBEEF in the cycle after DONE; ready low for cycles 0-6.
- Store 0x12345678 at 1028, then load from 1028 back-to-back: sram_addr values 2 then 3; read_data=0x12345678; each access takes 8 cycles.
- Assert rd_en and wr_en together at 1032 with data 0x0000A5A5: performed as a write, with no sram_oe_n assertion.
- Assert rst in cycle 3 of a load: next cycle state is IDLE, read_data=0, sram_oe_n=1, ready=1; a following load from 1024 still returns 0xDEADBEEF.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_e      : controller FSM states
//   DEF_MEM_BASE : default byte address mapped to SRAM word 0
//   DEF_SRAM_AW  : default SRAM halfword address width
//   SRAM_DW      : SRAM data bus width
//   WORD_W       : pipeline word width
//   CNT_W        : phase wait counter width (covers WAIT_CYCLES up to 15)
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  localparam int DEF_MEM_BASE = 1024;
  localparam int DEF_SRAM_AW  = 18;
  localparam int SRAM_DW      = 16;
  localparam int WORD_W       = 32;
  localparam int CNT_W        = 4;
endpackage

// File: rtl/sram_phase_timer.sv
// Wait counter for one 16-bit SRAM phase, shared by the LOW and HIGH phases.
//   clk, rst : clock, synchronous active-high reset
//   start    : clear the counter (new access accepted)
//   en       : count while a phase is active; wraps to 0 after the last cycle
//   count    : current cycle within the phase, 0..WAIT_CYCLES-1
//   last     : count is on the final cycle of the phase
module sram_phase_timer
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last
);
  logic [CNT_W-1:0] count_q, count_d;

  assign count = count_q;
  assign last  = (count_q == CNT_W'(WAIT_CYCLES - 1));

  always_comb begin
    count_d = count_q;
    if (start)      count_d = '0;
    else if (en)    count_d = last ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end
endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage controller between the EXE stage register and a 16-bit async SRAM.
// Each 32-bit access runs as a LOW halfword phase then a HIGH halfword phase,
// WAIT_CYCLES cycles each. ready drops while an access is in flight and is the
// pipeline-wide freeze (inverted) at the top level.
//   clk, rst           : clock, synchronous active-high reset
//   rd_en, wr_en       : load / store request (store wins if both set)
//   address            : byte address; write_data : store data
//   read_data          : last loaded word, held until the next load completes
//   ready              : no access pending, or access completing this cycle
//   sram_addr          : halfword address {word, half}
//   sram_dq_out/_in/_oe: SRAM data bus out / in / output enable
//   sram_we_n, sram_oe_n : active-low write strobe / output enable
module sram_mem_controller
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 3,
  parameter int MEM_BASE    = DEF_MEM_BASE,
  parameter int SRAM_AW     = DEF_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [WORD_W-1:0]  address,
  input  logic [WORD_W-1:0]  write_data,
  output logic [WORD_W-1:0]  read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);
  state_e             state_q, state_d;
  logic               op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0] word_q, word_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [WORD_W-1:0]  rdata_q, rdata_d;

  logic             req, accept, busy, last;
  logic [CNT_W-1:0] count;

  assign req    = rd_en | wr_en;
  assign accept = (state_q == IDLE) && req;
  assign busy   = (state_q == LOW) || (state_q == HIGH);

  sram_phase_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .en    (busy),
    .count (count),
    .last  (last)
  );

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LOW;
        op_wr_d = wr_en;
        // Out-of-range addresses simply wrap: the word index is truncated.
        word_d  = (SRAM_AW-1)'((address - WORD_W'(MEM_BASE)) >> 2);
        wdata_d = write_data;
      end
      LOW: if (last) begin
        state_d = HIGH;
        if (!op_wr_q) rdata_d[SRAM_DW-1:0] = sram_dq_in;
      end
      HIGH: if (last) begin
        state_d = DONE;
        if (!op_wr_q) rdata_d[WORD_W-1:SRAM_DW] = sram_dq_in;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    sram_addr   = {word_q, state_q == HIGH};
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (busy) begin
      if (op_wr_q) begin
        sram_dq_oe  = 1'b1;
        sram_dq_out = (state_q == HIGH) ? wdata_q[WORD_W-1:SRAM_DW] : wdata_q[SRAM_DW-1:0];
        // Release the strobe on the final cycle of the phase so data and
        // address stay valid past the rising edge of we_n.
        sram_we_n   = (count == CNT_W'(WAIT_CYCLES - 1));
      end else begin
        sram_oe_n   = 1'b0;
      end
    end
  end

  assign read_data = rdata_q;
  // Requests are ignored under reset, so the pipeline is never frozen then.
  assign ready = rst | ((state_q == IDLE) & ~req) | (state_q == DONE);
endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with a small behavioural SRAM.
module tb_sram_mem_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  int n_chk = 0;
  int n_fail = 0;

  sram_mem_controller dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: 256 halfwords, indexed by the low address bits.
  logic [15:0] mem [0:255];
  always @(posedge clk)
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
  assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[7:0]];

  typedef struct {
    string       name;
    logic        rd, wr, exp_wr;
    logic [31:0] addr, wdata;
    logic [17:0] a_lo, a_hi;
    logic [15:0] d_lo, d_hi;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one access starting in the current cycle (called just after a rising
  // edge); returns just after the edge that ends DONE, i.e. in the next cycle.
  task automatic access(input vec_t v);
    int   idx;
    logic hi;
    rd_en = v.rd; wr_en = v.wr; address = v.addr; write_data = v.wdata;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("%s ready c%0d", v.name, c), {31'b0, ready}, {31'b0, c == 7});
      if (c >= 1 && c <= 6) begin
        idx = (c - 1) % 3;
        hi  = (c >= 4);
        chk($sformatf("%s addr c%0d", v.name, c), {14'b0, sram_addr}, {14'b0, hi ? v.a_hi : v.a_lo});
        chk($sformatf("%s oe_n c%0d", v.name, c), {31'b0, sram_oe_n}, {31'b0, v.exp_wr});
        chk($sformatf("%s dq_oe c%0d", v.name, c), {31'b0, sram_dq_oe}, {31'b0, v.exp_wr});
        chk($sformatf("%s we_n c%0d", v.name, c), {31'b0, sram_we_n}, {31'b0, !(v.exp_wr && idx != 2)});
        if (v.exp_wr)
          chk($sformatf("%s dq_out c%0d", v.name, c), {16'b0, sram_dq_out}, {16'b0, hi ? v.d_hi : v.d_lo});
      end else begin
        chk($sformatf("%s idle we_n c%0d", v.name, c), {31'b0, sram_we_n}, 32'd1);
        chk($sformatf("%s idle oe_n c%0d", v.name, c), {31'b0, sram_oe_n}, 32'd1);
      end
      @(posedge clk); #1;
      if (c == 0) begin
        // Request is latched; later input changes must be ignored.
        rd_en = 1'b0; wr_en = 1'b0; address = 32'hFFFF_FFF0; write_data = 32'h5555_AAAA;
      end
    end
    chk({v.name, " read_data"}, read_data, v.exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //         name          rd wr ewr addr      wdata         a_lo      a_hi      d_lo     d_hi     exp_rdata
    vecs[0] = '{"st1024",    0, 1, 1, 32'd1024, 32'hDEADBEEF, 18'd0,    18'd1,    16'hBEEF, 16'hDEAD, 32'h00000000};
    vecs[1] = '{"ld1024",    1, 0, 0, 32'd1024, 32'h0,        18'd0,    18'd1,    16'h0,    16'h0,    32'hDEADBEEF};
    vecs[2] = '{"st1028",    0, 1, 1, 32'd1028, 32'h12345678, 18'd2,    18'd3,    16'h5678, 16'h1234, 32'hDEADBEEF};
    vecs[3] = '{"ld1028",    1, 0, 0, 32'd1028, 32'h0,        18'd2,    18'd3,    16'h0,    16'h0,    32'h12345678};
    vecs[4] = '{"rdwr1032",  1, 1, 1, 32'd1032, 32'h0000A5A5, 18'd4,    18'd5,    16'hA5A5, 16'h0000, 32'h12345678};
    vecs[5] = '{"ld1032",    1, 0, 0, 32'd1032, 32'h0,        18'd4,    18'd5,    16'h0,    16'h0,    32'h0000A5A5};
    vecs[6] = '{"st1424",    0, 1, 1, 32'd1424, 32'hCAFEF00D, 18'd200,  18'd201,  16'hF00D, 16'hCAFE, 32'h0000A5A5};
    vecs[7] = '{"ld1424",    1, 0, 0, 32'd1424, 32'h0,        18'd200,  18'd201,  16'h0,    16'h0,    32'hCAFEF00D};
    vecs[8] = '{"st1020wrap",0, 1, 1, 32'd1020, 32'h0BADF00D, 18'h3FFFE,18'h3FFFF,16'hF00D, 16'h0BAD, 32'hCAFEF00D};
    vecs[9] = '{"ld1020wrap",1, 0, 0, 32'd1020, 32'h0,        18'h3FFFE,18'h3FFFF,16'h0,    16'h0,    32'h0BADF00D};

    // Reset with a request pending: request is ignored, ready stays high.
    rst = 1'b1; rd_en = 1'b1; address = 32'd1024;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst ready with rd_en", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("rst ready", {31'b0, ready}, 32'd1);
    chk("rst we_n", {31'b0, sram_we_n}, 32'd1);
    chk("rst oe_n", {31'b0, sram_oe_n}, 32'd1);
    chk("rst dq_oe", {31'b0, sram_dq_oe}, 32'd0);
    chk("rst read_data", read_data, 32'd0);
    chk("rst sram_addr", {14'b0, sram_addr}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back accesses, each entered from IDLE.
    for (int i = 0; i < 10; i++) access(vecs[i]);

    // Reset in cycle 3 of a load aborts it and clears read_data.
    rd_en = 1'b1; address = 32'd1028;
    @(posedge clk); #1; rd_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort oe_n before rst", {31'b0, sram_oe_n}, 32'd0);
    chk("abort ready in rst", {31'b0, ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort ready", {31'b0, ready}, 32'd1);
    chk("abort oe_n", {31'b0, sram_oe_n}, 32'd1);
    chk("abort we_n", {31'b0, sram_we_n}, 32'd1);
    chk("abort read_data", read_data, 32'd0);
    @(posedge clk); #1;
    access('{"ld1024 after rst", 1, 0, 0, 32'd1024, 32'h0, 18'd0, 18'd1, 16'h0, 16'h0, 32'hDEADBEEF});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
